// File: rtl/poker_types.sv
// Shared card-game types.
// Provides the card encoding (card_t), the deck size and the dealer FSM
// state type, plus two small combinational helpers used by deck_dealer:
//   init_card : canonical card for deck slot i (suit = i/13, rank = i%13)
//   fy_index  : Fisher-Yates swap partner j = (r * n) >> 16, always < n
package poker_types;

   localparam int DECK_SIZE = 52;
   localparam int RANKS     = 13;

   typedef enum logic [1:0] {
      SUIT_CLUBS    = 2'd0,
      SUIT_DIAMONDS = 2'd1,
      SUIT_HEARTS   = 2'd2,
      SUIT_SPADES   = 2'd3
   } suit_e;

   // rank 0..12 encodes 2..A
   typedef struct packed {
      suit_e      suit;
      logic [3:0] rank;
   } card_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_INIT    = 2'd1,
      ST_SHUFFLE = 2'd2,
      ST_DEALING = 2'd3
   } dealer_state_e;

   function automatic card_t init_card(input logic [5:0] i);
      logic [5:0] q;
      logic [5:0] r;
      card_t      c;
      q      = i / 6'(RANKS);
      r      = i % 6'(RANKS);
      c.suit = suit_e'(q[1:0]);
      c.rank = r[3:0];
      return c;
   endfunction

   // 16-bit random scaled into 0..n-1 with a 22-bit product; the top six
   // bits of the product are the index.
   function automatic logic [5:0] fy_index(input logic [15:0] rnd,
                                           input logic [5:0]  n);
      logic [21:0] p;
      p = {6'd0, rnd} * {16'd0, n};
      return p[21:16];
   endfunction

endpackage

// File: rtl/deck_lfsr.sv
// 16-bit Galois LFSR used as the shuffle randomness source.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (value -> INIT_VAL)
//   load        : load load_val this cycle (takes priority over step)
//   load_val    : value to load
//   step        : advance one Galois step this cycle
//   value       : current LFSR state
module deck_lfsr #(
   parameter logic [15:0] INIT_VAL = 16'hACE1,
   parameter logic [15:0] MASK     = 16'hB400
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] load_val,
   input  logic        step,
   output logic [15:0] value
);

   logic [15:0] value_q;
   logic [15:0] value_d;

   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = load_val;
      end else if (step) begin
         // Galois form: shift right, fold the mask in when the LSB falls out
         value_d = value_q[0] ? ((value_q >> 1) ^ MASK) : (value_q >> 1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) value_q <= INIT_VAL;
      else       value_q <= value_d;
   end

   assign value = value_q;

endmodule

// File: rtl/deck_dealer.sv
// Card dealer: builds a 52-card deck, Fisher-Yates shuffles it with an
// LFSR, then deals one card per deal_req.
// Optional feature macro: POKER_SHUFFLE_SEED_EN adds a 16-bit seed input
// loaded into the LFSR on shuffle_start (zero seed -> LFSR_INIT).
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   seed           : shuffle seed (only with POKER_SHUFFLE_SEED_EN)
//   shuffle_start  : pulse; rebuild + shuffle from any state
//   deal_req       : request one card
//   card_out       : dealt card, held between deals
//   card_valid     : one-cycle pulse per dealt card
//   busy           : deck build / shuffle in progress (103 cycles)
//   ready          : dealing with cards remaining
//   cards_left     : 0..52
//   deal_err       : one-cycle pulse on a request to an empty deck
module deck_dealer
   import poker_types::*;
#(
   parameter logic [15:0] LFSR_INIT = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
`ifdef POKER_SHUFFLE_SEED_EN
   input  logic [15:0] seed,
`endif
   input  logic        shuffle_start,
   input  logic        deal_req,
   output card_t       card_out,
   output logic        card_valid,
   output logic        busy,
   output logic        ready,
   output logic [5:0]  cards_left,
   output logic        deal_err
);

   localparam logic [5:0] DECK_CNT = 6'(DECK_SIZE);
   localparam logic [5:0] LAST_IDX = 6'(DECK_SIZE - 1);

   dealer_state_e state_q, state_d;
   logic [5:0]    idx_q, idx_d;
   logic [5:0]    cards_left_q, cards_left_d;
   card_t         card_out_q, card_out_d;
   logic          card_valid_q, card_valid_d;
   logic          deal_err_q, deal_err_d;
   card_t         deck_q [DECK_SIZE];
   card_t         deck_d [DECK_SIZE];

   logic [15:0]   lfsr_val;
   logic          lfsr_load;
   logic [15:0]   lfsr_load_val;
   logic [5:0]    shuf_j;

`ifdef POKER_SHUFFLE_SEED_EN
   assign lfsr_load     = shuffle_start;
   assign lfsr_load_val = (seed == 16'd0) ? LFSR_INIT : seed;
`else
   // LFSR free-runs across shuffles; only reset re-seeds it
   assign lfsr_load     = 1'b0;
   assign lfsr_load_val = LFSR_INIT;
`endif

   deck_lfsr #(
      .INIT_VAL (LFSR_INIT),
      .MASK     (16'hB400)
   ) u_lfsr (
      .clk      (clk),
      .reset    (reset),
      .load     (lfsr_load),
      .load_val (lfsr_load_val),
      .step     (state_q == ST_SHUFFLE),
      .value    (lfsr_val)
   );

   // swap partner for slot idx_q, drawn from 0..idx_q
   assign shuf_j = fy_index(lfsr_val, idx_q + 6'd1);

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cards_left_d = cards_left_q;
      card_out_d   = card_out_q;
      card_valid_d = 1'b0;
      deal_err_d   = 1'b0;
      deck_d       = deck_q;

      // shuffle_start overrides everything, including a same-cycle deal_req
      if (shuffle_start) begin
         state_d      = ST_INIT;
         idx_d        = 6'd0;
         cards_left_d = 6'd0;
      end else begin
         case (state_q)
            ST_IDLE: ;
            ST_INIT: begin
               deck_d[idx_q] = init_card(idx_q);
               if (idx_q == LAST_IDX) begin
                  state_d = ST_SHUFFLE;   // idx stays at 51 for first swap
               end else begin
                  idx_d = idx_q + 6'd1;
               end
            end
            ST_SHUFFLE: begin
               deck_d[idx_q]  = deck_q[shuf_j];
               deck_d[shuf_j] = deck_q[idx_q];
               if (idx_q == 6'd1) begin
                  state_d      = ST_DEALING;
                  cards_left_d = DECK_CNT;
               end else begin
                  idx_d = idx_q - 6'd1;
               end
            end
            ST_DEALING: begin
               if (deal_req) begin
                  if (cards_left_q != 6'd0) begin
                     card_valid_d = 1'b1;
                     card_out_d   = deck_q[DECK_CNT - cards_left_q];
                     cards_left_d = cards_left_q - 6'd1;
                  end else begin
                     deal_err_d = 1'b1;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         idx_q        <= 6'd0;
         cards_left_q <= 6'd0;
         card_out_q   <= '0;
         card_valid_q <= 1'b0;
         deal_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cards_left_q <= cards_left_d;
         card_out_q   <= card_out_d;
         card_valid_q <= card_valid_d;
         deal_err_q   <= deal_err_d;
      end
   end

   // Deck contents need no reset: INIT rewrites every slot before use.
   always_ff @(posedge clk) begin
      deck_q <= deck_d;
   end

   assign card_out   = card_out_q;
   assign card_valid = card_valid_q;
   assign deal_err   = deal_err_q;
   assign cards_left = cards_left_q;
   assign busy       = (state_q == ST_INIT) || (state_q == ST_SHUFFLE);
   assign ready      = (state_q == ST_DEALING) && (cards_left_q != 6'd0);

endmodule

// File: tb/tb_deck_dealer.sv
// Randomized self-checking bench for deck_dealer against a behavioural
// Fisher-Yates / Galois-LFSR deck model.
module tb_deck_dealer;
   import poker_types::*;

   localparam logic [15:0] INIT_SEED = 16'hACE1;

   logic       clk = 1'b0;
   logic       reset;
   logic       shuffle_start;
   logic       deal_req;
   card_t      card_out;
   logic       card_valid;
   logic       busy;
   logic       ready;
   logic [5:0] cards_left;
   logic       deal_err;
`ifdef POKER_SHUFFLE_SEED_EN
   logic [15:0] seed;
`endif

   deck_dealer #(.LFSR_INIT(INIT_SEED)) dut (
      .clk           (clk),
      .reset         (reset),
`ifdef POKER_SHUFFLE_SEED_EN
      .seed          (seed),
`endif
      .shuffle_start (shuffle_start),
      .deal_req      (deal_req),
      .card_out      (card_out),
      .card_valid    (card_valid),
      .busy          (busy),
      .ready         (ready),
      .cards_left    (cards_left),
      .deal_err      (deal_err)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] m_lfsr;
   logic [5:0]  m_deck  [52];
   int          m_left;
   logic [5:0]  seq_cur [52];
   logic [5:0]  seq_a   [52];
   logic [5:0]  seq_b   [52];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Ordered deck, then swap i with floor(r*(i+1)/65536) for i = 51..1.
   function automatic void model_shuffle();
      for (int i = 0; i < 52; i++) m_deck[i] = 6'((i / 13) * 16 + (i % 13));
      for (int i = 51; i >= 1; i--) begin
         int unsigned j;
         logic [5:0]  t;
         j = (32'(m_lfsr) * 32'(i + 1)) >> 16;
         t = m_deck[i]; m_deck[i] = m_deck[j]; m_deck[j] = t;
         m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
      end
      m_left = 52;
   endfunction

   task automatic start_shuffle(input logic also_deal);
      int   n;
      logic bad;
`ifdef POKER_SHUFFLE_SEED_EN
      m_lfsr = (seed == 16'd0) ? INIT_SEED : seed;
`endif
      shuffle_start = 1'b1;
      deal_req      = also_deal;
      tick();
      shuffle_start = 1'b0;
      deal_req      = 1'b0;
      chk("start_no_valid", 32'(card_valid), 0);
      chk("start_no_err",   32'(deal_err), 0);
      chk("start_busy",     32'(busy), 1);
      chk("start_left0",    32'(cards_left), 0);
      n   = 0;
      bad = 1'b0;
      while (busy && n < 200) begin
         n++;
         deal_req = 1'($urandom_range(0, 1));
         tick();
         if (card_valid || deal_err || (busy && cards_left != 6'd0)) bad = 1'b1;
      end
      deal_req = 1'b0;
      chk("busy_quiet",  32'(bad), 0);
      chk("busy_len",    32'(n), 103);
      chk("ready_after", 32'(ready), 1);
      chk("left52",      32'(cards_left), 52);
      model_shuffle();
   endtask

   task automatic deal_n(input int cnt);
      int    got;
      int    guard;
      logic  req;
      card_t prev;
      got   = 0;
      guard = 0;
      while (got < cnt && guard < 1000) begin
         guard++;
         req      = ($urandom_range(0, 3) != 0);
         deal_req = req;
         prev     = card_out;
         tick();
         if (req) begin
            chk("card_valid", 32'(card_valid), 1);
            chk("card_out",   32'(card_out), 32'(m_deck[52 - m_left]));
            seq_cur[52 - m_left] = card_out;
            m_left--;
            chk("cards_left", 32'(cards_left), 32'(m_left));
            got++;
         end else begin
            chk("idle_valid", 32'(card_valid), 0);
            chk("hold_out",   32'(card_out), 32'(prev));
         end
      end
      deal_req = 1'b0;
      chk("deal_count", 32'(got), 32'(cnt));
   endtask

   task automatic check_distinct();
      int cnt [64];
      int missing;
      foreach (cnt[k]) cnt[k] = 0;
      for (int i = 0; i < 52; i++) cnt[seq_cur[i]]++;
      missing = 0;
      for (int s = 0; s < 4; s++)
         for (int r = 0; r < 13; r++)
            if (cnt[s * 16 + r] != 1) missing++;
      chk("all_distinct", 32'(missing), 0);
   endtask

   function automatic int seq_diff(input logic [5:0] a [52], input logic [5:0] b [52]);
      int d;
      d = 0;
      for (int i = 0; i < 52; i++) if (a[i] != b[i]) d++;
      return d;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset         = 1'b1;
      shuffle_start = 1'b0;
      deal_req      = 1'b0;
`ifdef POKER_SHUFFLE_SEED_EN
      seed          = 16'd0;
`endif
      m_lfsr        = INIT_SEED;
      m_left        = 0;
      tick(); tick();
      chk("rst_busy",  32'(busy), 0);
      chk("rst_ready", 32'(ready), 0);
      chk("rst_left",  32'(cards_left), 0);
      chk("rst_valid", 32'(card_valid), 0);
      chk("rst_err",   32'(deal_err), 0);
      chk("rst_card",  32'(card_out), 0);
      @(negedge clk);
      reset = 1'b0;

      // requests in IDLE are ignored
      deal_req = 1'b1;
      tick();
      deal_req = 1'b0;
      chk("idle_no_valid", 32'(card_valid), 0);
      chk("idle_no_err",   32'(deal_err), 0);

      // full shuffle + deal, random gaps
      start_shuffle(1'b0);
      deal_n(52);
      check_distinct();
      seq_a = seq_cur;

      // empty deck request
      deal_req = 1'b1;
      tick();
      deal_req = 1'b0;
      chk("empty_err",   32'(deal_err), 1);
      chk("empty_valid", 32'(card_valid), 0);
      chk("empty_left",  32'(cards_left), 0);
      chk("empty_ready", 32'(ready), 0);
      tick();
      chk("err_pulse", 32'(deal_err), 0);

      // second shuffle without reset must differ
`ifdef POKER_SHUFFLE_SEED_EN
      seed = 16'h1234;
`endif
      start_shuffle(1'b0);
      deal_n(52);
      check_distinct();
      seq_b = seq_cur;
      chk("reshuffle_differs", 32'(seq_diff(seq_a, seq_b) != 0), 1);

      // shuffle_start beats deal_req at 30 cards left
      start_shuffle(1'b0);
      deal_n(22);
      chk("left30", 32'(cards_left), 30);
      start_shuffle(1'b1);
      deal_n(52);

      // reset 20 cycles into SHUFFLE
      shuffle_start = 1'b1;
      tick();
      shuffle_start = 1'b0;
      repeat (52 + 20) tick();
      chk("mid_shuffle_busy", 32'(busy), 1);
      #2 reset = 1'b1;
      #1;
      chk("arst_busy",  32'(busy), 0);
      chk("arst_ready", 32'(ready), 0);
      chk("arst_left",  32'(cards_left), 0);
      chk("arst_valid", 32'(card_valid), 0);
      chk("arst_err",   32'(deal_err), 0);
      chk("arst_card",  32'(card_out), 0);
      @(negedge clk);
      reset  = 1'b0;
      m_lfsr = INIT_SEED;
`ifdef POKER_SHUFFLE_SEED_EN
      seed   = 16'd0;
`endif
      tick(); tick();
      chk("post_rst_idle", 32'(busy), 0);
      start_shuffle(1'b0);
      deal_n(52);
      chk("fresh_eq_first", 32'(seq_diff(seq_cur, seq_a)), 0);

`ifdef POKER_SHUFFLE_SEED_EN
      seed = 16'd0;
      start_shuffle(1'b0);
      deal_n(52);
      chk("seed0_eq_init", 32'(seq_diff(seq_cur, seq_a)), 0);
      seed = 16'h1234;
      start_shuffle(1'b0);
      deal_n(52);
      chk("seed_repeat", 32'(seq_diff(seq_cur, seq_b)), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/deck_dealer.md
DECK_DEALER -- requirements
Module: deck_dealer

Interface
REQ-001 Parameter: LFSR_INIT, 16'hACE1, LFSR value after reset and the fallback value for a zero seed.
REQ-002 clk  input  1  system clock; all registers update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 shuffle_start  input  1  single-cycle pulse; rebuilds and shuffles the deck from any state.
REQ-005 deal_req  input  1  request one card; sampled on each clk edge.
REQ-006 card_out  output  card_t (6)  dealt card; valid only while card_valid is high.
REQ-007 card_valid  output  1  one-cycle pulse per dealt card.
REQ-008 busy  output  1  high while the deck is being built or shuffled.
REQ-009 ready  output  1  high in DEALING with cards_left > 0.
REQ-010 cards_left  output  6  cards remaining in the deck, 0..52.
REQ-011 deal_err  output  1  one-cycle pulse when deal_req arrives in DEALING with cards_left == 0.

Function
REQ-012 The FSM shall have states IDLE, INIT, SHUFFLE and DEALING.
REQ-013 Transitions: IDLE --shuffle_start--> INIT; INIT --52 cycles--> SHUFFLE; SHUFFLE --51 cycles--> DEALING.
REQ-014 shuffle_start in any state shall force INIT on the next edge, with the index counter cleared.
REQ-015 INIT shall write one slot per cycle: deck[i] = {suit = i/13, rank = i%13}, for i = 0..51.
REQ-016 SHUFFLE shall perform one Fisher-Yates swap per cycle, for i = 51 down to 1: j = (lfsr[15:0] * (i+1)) >> 16, then swap deck[i] and deck[j].
REQ-017 The shuffle arithmetic shall use a 22-bit product; j shall always lie in 0..i.
REQ-018 The LFSR shall be a 16-bit Galois LFSR with mask 16'hB400.
REQ-019 The LFSR shall advance exactly once per SHUFFLE cycle and hold in all other states.
REQ-020 busy shall be high for exactly 103 consecutive cycles after the edge that samples shuffle_start.
REQ-021 ready shall rise on the following cycle, with cards_left = 52.
REQ-022 In DEALING, deal_req high with cards_left > 0 shall, on the next cycle, produce card_valid = 1 and card_out = deck[52 - cards_left], and decrement cards_left.
REQ-023 Back-to-back deal_req shall yield one card per cycle.
REQ-024 deal_req shall be ignored, with no deal_err, in IDLE, INIT and SHUFFLE.
REQ-025 In DEALING with cards_left == 0, deal_req shall pulse deal_err on the next cycle; card_valid shall stay low and cards_left shall stay 0.
REQ-026 If shuffle_start and deal_req are high in the same cycle, shuffle_start shall win: no card is dealt and no deal_err is raised.
REQ-027 cards_left shall be 0 in INIT and SHUFFLE, and shall never wrap below 0.
REQ-028 card_out shall hold its last value when card_valid is low.

Reset
REQ-029 Reset shall asynchronously force state IDLE, lfsr = LFSR_INIT, cards_left = 0, card_out = 0, and card_valid, deal_err, busy and ready = 0.
REQ-030 Deck storage contents after reset shall be don't-care; INIT always rebuilds the deck.
REQ-031 Reset asserted mid-SHUFFLE or mid-DEALING shall abort the operation; after release the block shall wait in IDLE for shuffle_start.

Configuration
REQ-032 With POKER_SHUFFLE_SEED_EN defined, an input seed (input, 16 bits) shall be added.
REQ-033 With POKER_SHUFFLE_SEED_EN defined, the LFSR shall load seed on the edge that samples shuffle_start; a seed of 0 shall load LFSR_INIT instead.
REQ-034 Without POKER_SHUFFLE_SEED_EN, there shall be no seed port and the LFSR shall continue from its current value at each shuffle_start.

Structure
REQ-035 card_t (packed struct: suit[1:0] = clubs, diamonds, hearts, spades; rank[3:0] = 0..12 for 2..A) shall be defined in the shared poker_types.svh package.
REQ-036 DECK_SIZE = 52 shall also be defined in the shared poker_types.svh package.
REQ-037 LFSR stepping shall be a sub-module deck_lfsr (ports: clk, reset, load, load_val, step, value).
REQ-038 Deck storage shall be a 52-entry card_t register array inside deck_dealer.

Verification
REQ-039 Reset, shuffle_start pulse, then 52 consecutive deal_req -> busy high for 103 cycles; 52 card_valid pulses; all 52 cards distinct with every suit/rank present; cards_left counts 52..0.
REQ-040 Deck at 0 cards, deal_req -> deal_err pulse; card_valid low; cards_left = 0.
REQ-041 Default LFSR seed -> dealt sequence matches the bit-exact Fisher-Yates/LFSR model.
REQ-042 Second shuffle_start without reset -> a different sequence from the first shuffle.
REQ-043 Reset asserted at SHUFFLE cycle 20 and shuffle_start issued after release -> outputs at reset values; the following shuffle is identical to a shuffle from a fresh reset.
REQ-044 shuffle_start and deal_req high together at cards_left = 30 -> no card_valid; busy rises; cards_left = 0.
REQ-045 With POKER_SHUFFLE_SEED_EN defined: seed = 0 gives the same deck as the LFSR_INIT seed; seed = 16'h1234 gives the same deck across two runs.
